bcd_conv_arbiter: RTL and testbench
===================================

# bcd_conv_arbiter

Time-shares one `bin2bcd` converter between up to NREQ requesters: score, high score, snake length and timer. Round-robin arbitration picks one requester, registers its binary value into the converter, then captures the 4-digit BCD result into that requester's output register. Values above 9999 saturate to 9999 and set a per-requester overflow flag. The block sits between the game-state logic and the 7-segment/text display drivers.

## Interface
- NREQ, 4: number of requesters, 2..8.
- clk  in  1  system clock; one clock domain.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  level request per requester; req_bin slice must be stable while req is high.
- req_bin  in  NREQ*16  binary values; slice i = [16*i+15:16*i].
- gnt  out  NREQ  one-hot, one-cycle pulse: request accepted, value captured.
- done  out  NREQ  one-hot, one-cycle pulse: bcd_out/ovf slice i updated this cycle.
- bcd_out  out  NREQ*16  held BCD result per requester, 4 digits, slice i = [16*i+15:16*i].
- ovf  out  NREQ  held per requester; set when the last converted value was >9999.
- busy  out  1  high in CONV and WRITE.

## Operation
- FSM states:
  - IDLE: if any req is set, grant the winner, latch req_bin[winner] into bin_q and the winner index into sel_q, then go to CONV. Otherwise stay in IDLE.
  - CONV: bin_q drives the converter. Register its output into bcd_q and register (bin_q > 9999) into ovf_q. Go to WRITE.
  - WRITE: write bcd_out[sel_q] = ovf_q ? 16'h9999 : bcd_q and ovf[sel_q] = ovf_q. Pulse done[sel_q]. Go to IDLE.
- Arbitration is round-robin:
  - Search starts at index (last_gnt+1) mod NREQ.
  - After reset, last_gnt = NREQ-1, so req[0] has highest priority.
  - last_gnt updates only on a grant.
- The arbiter samples req only in IDLE. Requests raised during CONV or WRITE wait; they are not lost while req stays high.
- Requester protocol:
  - Drop req in the cycle after gnt.
  - If req is still high in the next IDLE, it is a fresh request and is arbitrated normally.
- Slices that are not being written hold their value. Only slice sel_q changes in WRITE.
- Converter arithmetic:
  - 16-bit input, 16-bit output holding the low 4 BCD digits. It is valid only for inputs ≤9999.
  - The saturation compare uses the full 16-bit bin_q.
- Reset (any state, including mid-conversion):
  - FSM goes to IDLE, and the in-flight conversion is discarded with no done pulse.
  - bcd_out = 0, ovf = 0, gnt = 0, done = 0, busy = 0, last_gnt = NREQ-1.

## Timing
- Request-to-grant: combinational from req in IDLE. gnt is asserted in the same cycle that req is seen in IDLE.
- For a grant in cycle t:
  - t+1 is CONV.
  - t+2 is WRITE with done high.
  - bcd_out is visible from t+3.
- Throughput: at most one grant per 3 cycles. The next grant can occur at t+3.
- busy is high in cycles t+1 and t+2.
- gnt and done are never high in the same cycle.
- The converter sits between two registers (bin_q, bcd_q), so no req_bin-to-bcd_out combinational path exists.
- Simultaneous requests: only one is granted per arbitration. Others are served in round-robin order on later IDLE cycles.

## Structure
- Shared package `disp_pkg`:
  - BCD_MAX_BIN = 16'd9999
  - BCD_SAT = 16'h9999
  - state enum {IDLE, CONV, WRITE}
  - DIGITS = 4
- Sub-module `rr_arbiter` (NREQ): inputs req and last_gnt; outputs one-hot gnt and gnt index. It is purely combinational.
- `bin2bcd` is instantiated once, unchanged, between bin_q and bcd_q.

## Test plan
- Reset, then req[2]=1 with value 1234: gnt[2] at t, done[2] at t+2, bcd_out slice 2 = 16'h1234, ovf[2]=0, all other slices 0.
- Value 10000 on req[0]: bcd_out slice 0 = 16'h9999, ovf[0]=1. Then value 42 on req[0]: slice 0 = 16'h0042, ovf[0]=0.
- req = 4'b1111 held for 12 cycles: grants occur in order 0,1,2,3 at 3-cycle spacing, and every slice matches its input.
- req[1] is raised during CONV of req[3]: gnt[1] is asserted at the first IDLE cycle after WRITE, i.e. the cycle after done[3].
- rst asserted during CONV of value 9999 on req[1]: no done pulse, all outputs 0. After reset release, req[0] wins over a simultaneous req[1].
- Boundary values 0, 9, 10, 99, 100, 9999 and 65535: results 0000, 0009, 0010, 0099, 0100, 9999, and 9999 with ovf=1.

Source files
------------

// File: rtl/disp_pkg.sv
// disp_pkg: shared display constants and types.
//   BCD_MAX_BIN : largest binary value that fits in four BCD digits
//   BCD_SAT     : BCD pattern shown when a value saturates
//   DIGITS      : number of BCD digits produced per value
//   state_t     : conversion sequencer states
package disp_pkg;
   localparam logic [15:0] BCD_MAX_BIN = 16'd9999;
   localparam logic [15:0] BCD_SAT     = 16'h9999;
   localparam int          DIGITS      = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CONV  = 2'd1,
      WRITE = 2'd2
   } state_t;
endpackage

// File: rtl/bcd_conv_arbiter_if.sv
// bcd_conv_arbiter_if: request/result bundle between the game-state logic
// (master) and the shared BCD converter arbiter (slave).
//   req, req_bin      : level requests and their binary values (16 bits per slice)
//   gnt, done         : one-hot single-cycle accept / result-written pulses
//   bcd_out, ovf      : held 4-digit BCD result and overflow flag per requester
//   busy              : converter occupied
interface bcd_conv_arbiter_if #(parameter int NREQ = 4);
   logic [NREQ-1:0]      req;
   logic [NREQ*16-1:0]   req_bin;
   logic [NREQ-1:0]      gnt;
   logic [NREQ-1:0]      done;
   logic [NREQ*16-1:0]   bcd_out;
   logic [NREQ-1:0]      ovf;
   logic                 busy;

   modport master (output req, req_bin, input gnt, done, bcd_out, ovf, busy);
   modport slave  (input req, req_bin, output gnt, done, bcd_out, ovf, busy);
endinterface

// File: rtl/bin2bcd.sv
// bin2bcd: combinational 16-bit binary to BCD (shift-and-add-3).
//   bin : binary input
//   bcd : low four BCD digits; only meaningful for bin <= 9999
module bin2bcd (
   input  logic [15:0] bin,
   output logic [15:0] bcd
);
   logic [19:0] sr;
   logic [15:0] b;

   function automatic logic [3:0] add3(input logic [3:0] d);
      return (d > 4'd4) ? d + 4'd3 : d;
   endfunction

   always_comb begin
      sr = '0;
      b  = bin;
      for (int i = 0; i < 16; i++) begin
         sr = {add3(sr[19:16]), add3(sr[15:12]), add3(sr[11:8]),
               add3(sr[7:4]), add3(sr[3:0])};
         sr = {sr[18:0], b[15]};
         b  = {b[14:0], 1'b0};
      end
      bcd = sr[15:0];
   end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   req      : request vector
//   last_gnt : index granted most recently; search starts one above it
//   gnt      : one-hot winner (zero when no request)
//   gnt_idx  : binary index of the winner
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last_gnt,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   gnt_idx
);
   logic          found;
   logic [IW-1:0] j;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      j       = '0;
      for (int k = 1; k <= NREQ; k++) begin
         j = IW'((int'(last_gnt) + k) % NREQ);
         if (!found && req[j]) begin
            found   = 1'b1;
            gnt[j]  = 1'b1;
            gnt_idx = j;
         end
      end
   end
endmodule

// File: rtl/bcd_conv_arbiter.sv
// bcd_conv_arbiter: time-shares one bin2bcd converter between NREQ requesters.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : slave side of bcd_conv_arbiter_if (req/req_bin in; gnt, done,
//         bcd_out, ovf, busy out)
//
// state | meaning
// IDLE  | arbitrate; on a grant latch value and index
// CONV  | converter output and overflow captured into bcd_q / ovf_q
// WRITE | result written to the winner's slice, done pulsed
module bcd_conv_arbiter
   import disp_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic              clk,
   input  logic              rst,
   bcd_conv_arbiter_if.slave bus
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   state_t                 state_q, state_d;
   logic [IW-1:0]          last_gnt_q, sel_q, arb_idx;
   logic [NREQ-1:0]        arb_gnt, gnt_c, done_c;
   logic                   busy_c;
   logic [15:0]            bin_q, bcd_q, conv_bcd;
   logic                   ovf_q;
   logic [NREQ-1:0][15:0]  req_bin_a;
   logic [NREQ-1:0][15:0]  bcd_arr_q;
   logic [NREQ-1:0]        ovf_arr_q;

   assign req_bin_a = bus.req_bin;

   rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
      .req      (bus.req),
      .last_gnt (last_gnt_q),
      .gnt      (arb_gnt),
      .gnt_idx  (arb_idx)
   );

   bin2bcd u_conv (
      .bin (bin_q),
      .bcd (conv_bcd)
   );

   always_comb begin
      state_d = state_q;
      gnt_c   = '0;
      done_c  = '0;
      busy_c  = 1'b0;
      case (state_q)
         IDLE: begin
            if (|bus.req) begin
               gnt_c   = arb_gnt;
               state_d = CONV;
            end
         end
         CONV: begin
            busy_c  = 1'b1;
            state_d = WRITE;
         end
         WRITE: begin
            busy_c        = 1'b1;
            done_c[sel_q] = 1'b1;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Pulses are masked while reset is held so a request cannot be
   // acknowledged in a cycle whose state update is being discarded.
   assign bus.gnt     = rst ? '0 : gnt_c;
   assign bus.done    = rst ? '0 : done_c;
   assign bus.busy    = rst ? 1'b0 : busy_c;
   assign bus.bcd_out = bcd_arr_q;
   assign bus.ovf     = ovf_arr_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         last_gnt_q <= IW'(NREQ - 1);
         sel_q      <= '0;
         bin_q      <= '0;
         bcd_q      <= '0;
         ovf_q      <= 1'b0;
         bcd_arr_q  <= '0;
         ovf_arr_q  <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (|bus.req) begin
                  bin_q      <= req_bin_a[arb_idx];
                  sel_q      <= arb_idx;
                  last_gnt_q <= arb_idx;
               end
            end
            CONV: begin
               bcd_q <= conv_bcd;
               ovf_q <= (bin_q > BCD_MAX_BIN);
            end
            WRITE: begin
               bcd_arr_q[sel_q] <= ovf_q ? BCD_SAT : bcd_q;
               ovf_arr_q[sel_q] <= ovf_q;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
module tb_bcd_conv_arbiter;
   localparam int NREQ = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   bcd_conv_arbiter_if #(.NREQ(NREQ)) bus ();

   bcd_conv_arbiter #(.NREQ(NREQ)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;

   // reference model state
   int          m_last;
   logic [15:0] m_bcd [NREQ];
   logic        m_ovf [NREQ];

   // requester-side stimulus state
   logic [NREQ-1:0] req_v;
   logic [15:0]     val [NREQ];
   bit              drop_after_gnt;
   int              pend_idx;
   logic [15:0]     pend_val;
   int              last_w;

   function automatic logic [15:0] to_bcd(input int v);
      int s;
      s = (v > 9999) ? 9999 : v;
      return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
   endfunction

   function automatic int pick(input logic [NREQ-1:0] r, input int last);
      for (int k = 1; k <= NREQ; k++) begin
         int j;
         j = (last + k) % NREQ;
         if (r[j]) return j;
      end
      return -1;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      bus.req     = req_v;
      bus.req_bin = {val[3], val[2], val[1], val[0]};
   endtask

   task automatic model_reset();
      m_last = NREQ - 1;
      for (int i = 0; i < NREQ; i++) begin
         m_bcd[i] = '0;
         m_ovf[i] = 1'b0;
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [NREQ*16-1:0] eb;
      logic [NREQ-1:0]    eo;
      for (int i = 0; i < NREQ; i++) begin
         eb[16*i +: 16] = m_bcd[i];
         eo[i]          = m_ovf[i];
      end
      check({tag, "_bcd"}, bus.bcd_out, eb);
      check({tag, "_ovf"}, bus.ovf, eo);
   endtask

   // Called just after a negedge while the DUT is in IDLE with req_v driven.
   // Ends just after the negedge of the cycle following WRITE.
   task automatic serve();
      int          w;
      logic [15:0] v;
      w = pick(req_v, m_last);
      last_w = w;
      check("gnt", bus.gnt, (w < 0) ? 64'd0 : (64'd1 << w));
      check("done_idle", bus.done, 64'd0);
      check("busy_idle", bus.busy, 64'd0);
      if (w < 0) return;
      m_last = w;
      v = val[w];
      @(negedge clk);
      if (drop_after_gnt) req_v[w] = 1'b0;
      if (pend_idx >= 0) begin
         val[pend_idx]   = pend_val;
         req_v[pend_idx] = 1'b1;
         pend_idx        = -1;
      end
      drive();
      #1;
      check("busy_conv", bus.busy, 64'd1);
      check("gnt_conv", bus.gnt, 64'd0);
      check("done_conv", bus.done, 64'd0);
      @(negedge clk);
      #1;
      check("done_write", bus.done, 64'd1 << w);
      check("gnt_write", bus.gnt, 64'd0);
      check("busy_write", bus.busy, 64'd1);
      m_bcd[w] = to_bcd(int'(v));
      m_ovf[w] = (v > 16'd9999);
      @(negedge clk);
      #1;
      check_outputs("result");
   endtask

   task automatic start(input int i, input logic [15:0] v);
      val[i]   = v;
      req_v[i] = 1'b1;
      drive();
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst   = 1'b1;
      req_v = '0;
      drive();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int bvals [7];
      req_v          = '0;
      drop_after_gnt = 1'b1;
      pend_idx       = -1;
      pend_val       = '0;
      last_w         = -1;
      for (int i = 0; i < NREQ; i++) val[i] = '0;
      drive();
      model_reset();

      // reset state
      @(negedge clk);
      @(negedge clk);
      #1;
      check("rst_gnt", bus.gnt, 64'd0);
      check("rst_done", bus.done, 64'd0);
      check("rst_busy", bus.busy, 64'd0);
      check_outputs("rst");
      rst = 1'b0;
      @(negedge clk);
      #1;

      // single request, slice 2
      start(2, 16'd1234);
      serve();
      check("t1_slice2", bus.bcd_out[47:32], 16'h1234);
      check("t1_others", {bus.bcd_out[63:48], bus.bcd_out[31:0]}, 48'd0);

      // saturation then clear on requester 0
      start(0, 16'd10000);
      serve();
      check("sat_slice0", bus.bcd_out[15:0], 16'h9999);
      check("sat_ovf0", bus.ovf[0], 1'b1);
      start(0, 16'd42);
      serve();
      check("clr_slice0", bus.bcd_out[15:0], 16'h0042);
      check("clr_ovf0", bus.ovf[0], 1'b0);

      // all four held: round-robin 0,1,2,3 after reset
      do_reset();
      drop_after_gnt = 1'b0;
      for (int i = 0; i < NREQ; i++) val[i] = 16'($urandom_range(0, 65535));
      req_v = '1;
      drive();
      #1;
      for (int k = 0; k < NREQ; k++) begin
         serve();
         check("rr_order", last_w, k);
      end
      req_v = '0;
      drive();
      drop_after_gnt = 1'b1;
      @(negedge clk);
      #1;

      // request raised during CONV waits for next IDLE
      pend_idx = 1;
      pend_val = 16'($urandom_range(0, 9999));
      start(3, 16'($urandom_range(0, 9999)));
      serve();
      serve();
      check("late_req_winner", last_w, 1);

      // reset during CONV of 9999 on requester 1
      start(1, 16'd9999);
      check("rstconv_gnt", bus.gnt, 64'h2);
      @(negedge clk);
      req_v = '0;
      drive();
      rst = 1'b1;
      @(negedge clk);
      #1;
      check("rstconv_done", bus.done, 64'd0);
      check("rstconv_busy", bus.busy, 64'd0);
      model_reset();
      check_outputs("rstconv");
      @(negedge clk);
      #1;
      check("rstconv_done2", bus.done, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      #1;
      check_outputs("after_rst");
      val[0]   = 16'($urandom_range(0, 65535));
      val[1]   = 16'($urandom_range(0, 65535));
      req_v[0] = 1'b1;
      req_v[1] = 1'b1;
      drive();
      #1;
      serve();
      check("post_rst_first", last_w, 0);
      serve();
      check("post_rst_second", last_w, 1);

      // boundary values
      bvals = '{0, 9, 10, 99, 100, 9999, 65535};
      for (int i = 0; i < 7; i++) begin
         start(i % NREQ, 16'(bvals[i]));
         serve();
      end
      check("bnd_65535_ovf", bus.ovf[2], 1'b1);
      check("bnd_65535_bcd", bus.bcd_out[47:32], 16'h9999);
      check("bnd_9999", bus.bcd_out[31:16], 16'h9999);

      // randomized request sets
      for (int it = 0; it < 15; it++) begin
         logic [NREQ-1:0] mask;
         mask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         for (int i = 0; i < NREQ; i++) begin
            if (mask[i]) begin
               val[i]   = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 12000))
                                                      : 16'($urandom_range(0, 65535));
               req_v[i] = 1'b1;
            end
         end
         drive();
         #1;
         for (int n = 0; n < NREQ && req_v != '0; n++) serve();
         check("rand_drained", req_v, 64'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
